mux_arb_reg: RTL and testbench

//  Parametrised N-channel, W-bit registered multiplexer with valid/ready handshake on every port.

---
 rtl/mux_arb_reg.sv | 119 +++++++++++
 tb/tb_mux_arb_reg.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mux_arb_reg.sv
// N-channel registered mux with direct/round-robin/fixed-priority arbitration and one output register.
// Latency: one edge from input transfer to out_valid_o; in_ready_o all low while the held beat is stalled.
module mux_arb_reg #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [1:0]                   mode_i,
  input  logic [$clog2(CHANNELS)-1:0]  sel_i,
  input  logic [CHANNELS-1:0]          in_valid_i,
  input  logic [CHANNELS*WIDTH-1:0]    in_data_i,
  output logic [CHANNELS-1:0]          in_ready_o,
  output logic                         out_valid_o,
  output logic [WIDTH-1:0]             out_data_o,
  output logic [$clog2(CHANNELS)-1:0]  out_ch_o,
  input  logic                         out_ready_i
);

  localparam int SELW = $clog2(CHANNELS);

  typedef enum logic [1:0] {
    MODE_DIRECT = 2'd0,
    MODE_RR     = 2'd1,
    MODE_PRIO   = 2'd2
  } mode_e;

  logic              vld_q, vld_d;
  logic [WIDTH-1:0]  dat_q, dat_d;
  logic [SELW-1:0]   ch_q, ch_d;
  logic [SELW-1:0]   rr_q, rr_d;

  logic              load;
  logic              gnt_vld;
  logic [SELW-1:0]   gnt_idx;
  logic [WIDTH-1:0]  gnt_dat;
  int                rr_idx;

  function automatic logic bit_of(input logic [CHANNELS-1:0] v, input int idx);
    return |(v & (CHANNELS'(1) << idx));
  endfunction

  assign load = !vld_q || out_ready_i;

  // Grant is purely a function of current requests; mode 3 falls through to fixed priority.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    rr_idx  = 0;
    case (mode_i)
      MODE_DIRECT: begin
        if (int'(sel_i) < CHANNELS && bit_of(in_valid_i, int'(sel_i))) begin
          gnt_vld = 1'b1;
          gnt_idx = sel_i;
        end
      end
      MODE_RR: begin
        for (int k = 1; k <= CHANNELS; k++) begin
          rr_idx = (int'(rr_q) + k) % CHANNELS;
          if (!gnt_vld && bit_of(in_valid_i, rr_idx)) begin
            gnt_vld = 1'b1;
            gnt_idx = SELW'(rr_idx);
          end
        end
      end
      default: begin
        for (int i = CHANNELS - 1; i >= 0; i--) begin
          if (bit_of(in_valid_i, i)) begin
            gnt_vld = 1'b1;
            gnt_idx = SELW'(i);
          end
        end
      end
    endcase
  end

  always_comb begin
    gnt_dat = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (gnt_idx == SELW'(i)) gnt_dat = in_data_i[i*WIDTH +: WIDTH];
    end
  end

  assign in_ready_o = (load && gnt_vld) ? (CHANNELS'(1) << gnt_idx) : '0;

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    ch_d  = ch_q;
    rr_d  = rr_q;
    if (load && gnt_vld) begin
      vld_d = 1'b1;
      dat_d = gnt_dat;
      ch_d  = gnt_idx;
      rr_d  = gnt_idx;
    end else if (out_ready_i) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      dat_q <= '0;
      ch_q  <= '0;
      rr_q  <= SELW'(CHANNELS - 1);
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
      ch_q  <= ch_d;
      rr_q  <= rr_d;
    end
  end

  assign out_valid_o = vld_q;
  assign out_data_o  = dat_q;
  assign out_ch_o    = ch_q;

endmodule

// File: tb/tb_mux_arb_reg.sv
// Directed bench for mux_arb_reg (WIDTH=4, CHANNELS=4); channel i carries data 4'hC+i.
module tb_mux_arb_reg;

  logic        clk;
  logic        rst_n;
  logic [1:0]  mode;
  logic [1:0]  sel;
  logic [3:0]  in_valid;
  logic [15:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [3:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_ready;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [1:0] mode;
    logic [1:0] sel;
    logic [3:0] iv;
    logic       ordy;
    logic [3:0] eir;
  } vec_t;

  vec_t       tbl [8];
  logic [1:0] exp_q [$];
  logic [1:0] exp_ch;
  int         pops;

  mux_arb_reg #(.WIDTH(4), .CHANNELS(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mode_i      (mode),
    .sel_i       (sel),
    .in_valid_i  (in_valid),
    .in_data_i   (in_data),
    .in_ready_o  (in_ready),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_ch_o    (out_ch),
    .out_ready_i (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b1;
    mode      = 2'd0;
    sel       = 2'd0;
    in_valid  = 4'h0;
    in_data   = {4'hF, 4'hE, 4'hD, 4'hC};
    out_ready = 1'b0;
    pops      = 0;
    #2 rst_n = 1'b0;
    cyc();
    cyc();
    chk("rst_vld", 32'(out_valid), 32'd0);
    chk("rst_dat", 32'(out_data), 32'd0);
    chk("rst_ch",  32'(out_ch), 32'd0);
    chk("rst_rdy", 32'(in_ready), 32'd0);
    rst_n = 1'b1;

    // Direct select, every channel in turn.
    mode = 2'd0; in_valid = 4'hF; out_ready = 1'b1;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      #1 chk("m0_rdy", 32'(in_ready), 32'(4'b0001 << s));
      cyc();
      chk("m0_vld", 32'(out_valid), 32'd1);
      chk("m0_dat", 32'(out_data), 32'(4'hC + s));
      chk("m0_ch",  32'(out_ch), 32'(s));
    end

    // Round robin from pointer 3: 0,1,2,3,0,1.
    mode = 2'd1;
    for (int k = 0; k < 6; k++) begin
      #1 chk("rr_rdy", 32'(in_ready), 32'(4'b0001 << (k % 4)));
      cyc();
      chk("rr_ch",  32'(out_ch), 32'(k % 4));
      chk("rr_dat", 32'(out_data), 32'(4'hC + (k % 4)));
    end

    // Fixed priority starves channel 3.
    mode = 2'd2; in_valid = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      #1 chk("fp_rdy", 32'(in_ready), 32'b0010);
      cyc();
      chk("fp_ch",  32'(out_ch), 32'd1);
      chk("fp_dat", 32'(out_data), 32'hD);
    end

    // Stall with ch1 held, ch3 waiting.
    out_ready = 1'b0; in_valid = 4'b1000;
    for (int k = 0; k < 3; k++) begin
      #1 chk("bp_rdy", 32'(in_ready), 32'd0);
      cyc();
      chk("bp_vld", 32'(out_valid), 32'd1);
      chk("bp_dat", 32'(out_data), 32'hD);
      chk("bp_ch",  32'(out_ch), 32'd1);
    end
    out_ready = 1'b1;
    #1 chk("bp_rel_rdy", 32'(in_ready), 32'b1000);
    cyc();
    chk("bp_rel_ch",  32'(out_ch), 32'd3);
    chk("bp_rel_dat", 32'(out_data), 32'hF);
    chk("bp_rel_vld", 32'(out_valid), 32'd1);

    // Direct select of an idle channel: output drains, beat fields hold.
    mode = 2'd0; sel = 2'd2; in_valid = 4'b1011;
    #1 chk("idle_rdy", 32'(in_ready), 32'd0);
    cyc();
    chk("idle_vld", 32'(out_valid), 32'd0);
    chk("idle_dat", 32'(out_data), 32'hF);
    chk("idle_ch",  32'(out_ch), 32'd3);

    // Mixed traffic with scoreboard; rr pointer starts at 3.
    tbl[0] = '{2'd1, 2'd0, 4'b0110, 1'b1, 4'b0010};
    tbl[1] = '{2'd1, 2'd0, 4'b0110, 1'b0, 4'b0000};
    tbl[2] = '{2'd1, 2'd0, 4'b0110, 1'b1, 4'b0100};
    tbl[3] = '{2'd0, 2'd3, 4'b1001, 1'b1, 4'b1000};
    tbl[4] = '{2'd3, 2'd0, 4'b0000, 1'b1, 4'b0000};
    tbl[5] = '{2'd3, 2'd0, 4'b1100, 1'b0, 4'b0100};
    tbl[6] = '{2'd2, 2'd0, 4'b1100, 1'b0, 4'b0000};
    tbl[7] = '{2'd0, 2'd2, 4'b1011, 1'b1, 4'b0000};
    for (int r = 0; r < 8; r++) begin
      mode = tbl[r].mode; sel = tbl[r].sel;
      in_valid = tbl[r].iv; out_ready = tbl[r].ordy;
      #1 chk("sb_rdy", 32'(in_ready), 32'(tbl[r].eir));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("sb_extra_beat", 32'(out_ch), 32'hFFFF);
        end else begin
          exp_ch = exp_q.pop_front();
          pops++;
          chk("sb_ch",  32'(out_ch), 32'(exp_ch));
          chk("sb_dat", 32'(out_data), 32'(4'hC + exp_ch));
        end
      end
      for (int b = 0; b < 4; b++) if (tbl[r].eir[b]) exp_q.push_back(2'(b));
      cyc();
    end
    chk("sb_pops",  32'(pops), 32'd4);
    chk("sb_left",  32'(exp_q.size()), 32'd0);
    chk("sb_drain", 32'(out_valid), 32'd0);

    // Asynchronous reset while a beat is held; pointer returns to 3.
    mode = 2'd0; sel = 2'd1; in_valid = 4'hF; out_ready = 1'b0;
    cyc();
    chk("pre_rst_vld", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_vld", 32'(out_valid), 32'd0);
    chk("arst_dat", 32'(out_data), 32'd0);
    chk("arst_ch",  32'(out_ch), 32'd0);
    cyc();
    rst_n = 1'b1;
    mode = 2'd1; out_ready = 1'b1;
    #1 chk("arst_rr_rdy", 32'(in_ready), 32'b0001);
    cyc();
    chk("arst_rr_ch", 32'(out_ch), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
